regfile_writeback_arbiter: RTL and testbench
============================================

# regfile_writeback_arbiter

Write-side front end for the register file: merges two writeback sources into the register file's single write port (`we`, `A3`, `wd`). The primary source is the core's in-order writeback and is normally granted at once. The secondary source is long-latency results such as mul/div or AMO, buffered in a small FIFO and granted on idle cycles or when starved. The block also flags read-after-write and write-after-write hazards against pending writes, so the core can stall operand fetch.

## Interface
- `REGISTER_WIDTH`, 32: data width.
- `FIFO_DEPTH`, 2: secondary buffer entries; power of two, >= 2.
- `STARVE_LIMIT`, 4: cycles the FIFO head may wait before it takes priority over the primary; >= 1.

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pri_valid`  in  1  primary write request.
- `pri_rd`  in  5  primary destination register.
- `pri_data`  in  REGISTER_WIDTH  primary write data.
- `pri_ready`  out  1  primary accepted this cycle (combinational).
- `sec_valid`  in  1  secondary write request.
- `sec_rd`  in  5  secondary destination register.
- `sec_data`  in  REGISTER_WIDTH  secondary write data.
- `sec_ready`  out  1  FIFO can accept; equals `fifo_count != FIFO_DEPTH`.
- `rf_we`  out  1  register file write enable (registered).
- `rf_A3`  out  5  register file write address (registered).
- `rf_wd`  out  REGISTER_WIDTH  register file write data (registered).
- `hz_A1`, `hz_A2`  in  5 each  source registers being fetched.
- `hz_rd`  in  5  destination of the instruction being issued.
- `hz_stall`  out  1  hazard against a pending write (combinational).
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  occupied FIFO entries.

## Operation
- **Secondary push.** A push occurs when `sec_valid && sec_ready`.
  - `sec_rd==0`: the handshake completes but nothing is stored.
  - Otherwise `{sec_rd, sec_data}` is written at the FIFO tail.
  - `sec_ready` depends only on the current count. When the FIFO is full, no push is accepted, even in a cycle where the head pops.
- **Grant priority**, evaluated each cycle, first match wins:
  1. `starve_cnt == STARVE_LIMIT` and FIFO non-empty: the FIFO head pops and `pri_ready=0`.
  2. `pri_valid`: the primary is accepted and `pri_ready=1`.
  3. FIFO non-empty: the FIFO head pops.
  4. Otherwise: idle.
- `pri_ready` is 1 in every case except case 1. That includes cycles with `pri_valid=0`.
- **Write issue.** The granted entry is registered into `rf_we/rf_A3/rf_wd` at the next edge.
  - `rf_we=1` only if the granted rd is non-zero. A primary with `pri_rd==0` completes its handshake with `rf_we=0`.
  - With no grant, `rf_we=0`. `rf_A3` and `rf_wd` hold their previous values.
- **Starve counter.**
  - Increments, saturating at `STARVE_LIMIT`, in each cycle the FIFO is non-empty and no pop occurs.
  - Clears to 0 on any pop, and while the FIFO is empty.
- **FIFO mechanics.** Push and pop in the same cycle are legal: the count is unchanged, pointers wrap modulo `FIFO_DEPTH`, and data order is strictly FIFO.
- **Hazard.** `hz_stall=1` when a non-zero register in {`hz_A1`, `hz_A2`, `hz_rd`} matches either of:
  - any valid FIFO entry rd;
  - `rf_A3`, when `rf_we=1`.
  
  The core must stall issue while `hz_stall=1`. This keeps secondary writes from landing after a younger primary write to the same register.
- **Reset** (synchronous, `reset=1` at an edge):
  - FIFO emptied, pointers 0, `fifo_count=0`, `starve_cnt=0`.
  - `rf_we=0`, `rf_A3=0`, `rf_wd=0`.
  - Combinational outputs after reset: `sec_ready=1`, `pri_ready=1`, `hz_stall=0`.
  - A reset mid-operation discards all buffered writes. No `rf_we` pulse is issued in the reset cycle or the cycle after it.

## Timing
- Primary: accept at edge N gives `rf_we/rf_A3/rf_wd` valid during cycle N+1. The register file commits at edge N+1.
- Secondary on an idle bus: push at edge N; the entry is at the head in cycle N+1 and pops then; `rf_we` is high in cycle N+2.
- Worst-case wait for the FIFO head under a continuous primary stream is `STARVE_LIMIT` cycles, plus 1 cycle for the pop.
- `hz_stall` and `pri_ready` are combinational from current state and inputs. There is no combinational path from `pri_valid` to `sec_ready`.
- Sustained throughput is one register write per cycle.

## Test plan
- **Primary only.** After reset, drive `pri_valid=1, pri_rd=5, pri_data=0xDEADBEEF` for 1 cycle. Next cycle: `rf_we=1, rf_A3=5, rf_wd=0xDEADBEEF`. The cycle after: `rf_we=0`.
- **Secondary on idle bus.** Push `sec_rd=7, 0x12345678` with no primary. `rf_we=1, rf_A3=7` appears 2 cycles after the push. `fifo_count` goes 1 then 0.
- **Full FIFO and starvation.** Push 2 secondary entries (rd 3, 4), then hold `pri_valid=1` continuously.
  - `sec_ready=0` while the count is 2.
  - After 4 primary grants, `pri_ready=0` for one cycle and rd 3 is written.
  - After 4 further primary grants, `pri_ready=0` for one cycle and rd 4 is written.
  - Primary order is preserved throughout.
- **x0 writes.** Primary `pri_rd=0` gives `pri_ready=1` with `rf_we` staying 0. Secondary `sec_rd=0` is accepted, `fifo_count` stays 0, and `rf_we` stays 0.
- **Hazard.** With rd 9 pending in the FIFO and the primary stream blocking its pop:
  - `hz_A2=9` gives `hz_stall=1`.
  - `hz_rd=9` gives `hz_stall=1`.
  - `hz_A1=0` with `hz_A2=0` and `hz_rd=0` gives `hz_stall=0`.
  - After the entry pops, `hz_stall` stays 1 while `rf_we=1, rf_A3=9`, then drops to 0.
- **Reset mid-operation.** Assert `reset` with 2 FIFO entries pending and `rf_we=1`. Next cycle: `fifo_count=0`, `rf_we=0`. No write to the pending rds ever occurs afterwards.

Source files
------------

// File: rtl/regfile_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_writeback_arbiter
// Purpose  : Merges in-order primary writeback and FIFO-buffered secondary
//            (long-latency) writeback onto the single register file write port.
//            Also flags hazards against pending writes.
// Revision : 1.0
// ============================================================================
module regfile_writeback_arbiter #(
    parameter int REGISTER_WIDTH = 32,
    parameter int FIFO_DEPTH     = 2,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          pri_valid,
    input  logic [4:0]                    pri_rd,
    input  logic [REGISTER_WIDTH-1:0]     pri_data,
    output logic                          pri_ready,
    input  logic                          sec_valid,
    input  logic [4:0]                    sec_rd,
    input  logic [REGISTER_WIDTH-1:0]     sec_data,
    output logic                          sec_ready,
    output logic                          rf_we,
    output logic [4:0]                    rf_A3,
    output logic [REGISTER_WIDTH-1:0]     rf_wd,
    input  logic [4:0]                    hz_A1,
    input  logic [4:0]                    hz_A2,
    input  logic [4:0]                    hz_rd,
    output logic                          hz_stall,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] c_full       = CNT_W'(FIFO_DEPTH);
    localparam logic [STV_W-1:0] c_starve_max = STV_W'(STARVE_LIMIT);

    logic [4:0]                r_mem_rd   [FIFO_DEPTH];
    logic [REGISTER_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
    logic [PTR_W-1:0]          r_wptr;
    logic [PTR_W-1:0]          r_rptr;
    logic [CNT_W-1:0]          r_count;
    logic [STV_W-1:0]          r_starve;
    logic                      r_we;
    logic [4:0]                r_a3;
    logic [REGISTER_WIDTH-1:0] r_wd;

    logic                      w_empty;
    logic                      w_starved;
    logic                      w_pop;
    logic                      w_pri_grant;
    logic                      w_push;
    logic [FIFO_DEPTH-1:0]     w_ent_hit;
    logic                      w_rf_hit;

    // A stored rd is never x0, so a match against it implies a non-zero source.
    function automatic logic f_hit(input logic [4:0] rd, input logic [4:0] a1,
                                   input logic [4:0] a2, input logic [4:0] dst);
        return (rd != 5'd0) && ((rd == a1) || (rd == a2) || (rd == dst));
    endfunction

    assign w_empty     = (r_count == '0);
    assign sec_ready   = (r_count != c_full);
    assign w_starved   = (r_starve == c_starve_max) && !w_empty;
    assign pri_ready   = !w_starved;
    assign w_pri_grant = pri_valid && !w_starved;
    assign w_pop       = !w_empty && (w_starved || !pri_valid);
    // x0 pushes complete the handshake but are dropped here.
    assign w_push      = sec_valid && sec_ready && (sec_rd != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_starve <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_pop || w_empty) begin
                r_starve <= '0;
            end else if (r_starve != c_starve_max) begin
                r_starve <= r_starve + STV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_wptr]   <= sec_rd;
            r_mem_data[r_wptr] <= sec_data;
        end
    end

    // Pop and primary grant are mutually exclusive by construction.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we <= 1'b0;
            r_a3 <= '0;
            r_wd <= '0;
        end else if (w_pop) begin
            r_we <= 1'b1;
            r_a3 <= r_mem_rd[r_rptr];
            r_wd <= r_mem_data[r_rptr];
        end else if (w_pri_grant) begin
            r_we <= (pri_rd != 5'd0);
            r_a3 <= pri_rd;
            r_wd <= pri_data;
        end else begin
            r_we <= 1'b0;
        end
    end

    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry_hit
        logic [PTR_W-1:0] w_off;
        logic             w_valid;
        assign w_off          = PTR_W'(gi) - r_rptr;
        assign w_valid        = ({1'b0, w_off} < r_count);
        assign w_ent_hit[gi]  = w_valid && f_hit(r_mem_rd[gi], hz_A1, hz_A2, hz_rd);
    end

    assign w_rf_hit   = r_we && f_hit(r_a3, hz_A1, hz_A2, hz_rd);
    assign hz_stall   = (|w_ent_hit) || w_rf_hit;

    assign rf_we      = r_we;
    assign rf_A3      = r_a3;
    assign rf_wd      = r_wd;
    assign fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_writeback_arbiter
// Purpose  : Self-checking bench: vector table, corner sequences, random vs model.
// Revision : 1.0
// ============================================================================
module tb_regfile_writeback_arbiter;

    localparam int W      = 32;
    localparam int DEPTH  = 2;
    localparam int STARVE = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         pri_valid;
    logic [4:0]   pri_rd;
    logic [W-1:0] pri_data;
    logic         pri_ready;
    logic         sec_valid;
    logic [4:0]   sec_rd;
    logic [W-1:0] sec_data;
    logic         sec_ready;
    logic         rf_we;
    logic [4:0]   rf_A3;
    logic [W-1:0] rf_wd;
    logic [4:0]   hz_A1;
    logic [4:0]   hz_A2;
    logic [4:0]   hz_rd;
    logic         hz_stall;
    logic [1:0]   fifo_count;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_writeback_arbiter #(
        .REGISTER_WIDTH(W),
        .FIFO_DEPTH    (DEPTH),
        .STARVE_LIMIT  (STARVE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pri_valid (pri_valid),
        .pri_rd    (pri_rd),
        .pri_data  (pri_data),
        .pri_ready (pri_ready),
        .sec_valid (sec_valid),
        .sec_rd    (sec_rd),
        .sec_data  (sec_data),
        .sec_ready (sec_ready),
        .rf_we     (rf_we),
        .rf_A3     (rf_A3),
        .rf_wd     (rf_wd),
        .hz_A1     (hz_A1),
        .hz_A2     (hz_A2),
        .hz_rd     (hz_rd),
        .hz_stall  (hz_stall),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [4:0]  prd;
        logic [31:0] pdat;
        logic        sv;
        logic [4:0]  srd;
        logic [31:0] sdat;
        logic        e_pr;
        logic        e_sr;
        logic        e_we;
        logic [4:0]  e_a3;
        logic [31:0] e_wd;
        logic [1:0]  e_cnt;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    vec_t        tbl [14];
    ent_t        mq [$];
    ent_t        g;
    int          mst;
    logic        m_we;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;

    function automatic vec_t mk(input logic pv, input logic [4:0] prd, input logic [31:0] pdat,
                                input logic sv, input logic [4:0] srd, input logic [31:0] sdat,
                                input logic e_pr, input logic e_sr, input logic e_we,
                                input logic [4:0] e_a3, input logic [31:0] e_wd,
                                input logic [1:0] e_cnt);
        vec_t v;
        v.pv = pv;   v.prd = prd;   v.pdat = pdat;
        v.sv = sv;   v.srd = srd;   v.sdat = sdat;
        v.e_pr = e_pr; v.e_sr = e_sr; v.e_we = e_we;
        v.e_a3 = e_a3; v.e_wd = e_wd; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle_in();
        pri_valid = 1'b0; pri_rd = 5'd0; pri_data = '0;
        sec_valid = 1'b0; sec_rd = 5'd0; sec_data = '0;
        hz_A1 = 5'd0; hz_A2 = 5'd0; hz_rd = 5'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int          k;
        logic        starved;
        logic        hz_exp;
        logic        popped;
        logic        granted;
        logic        rst_now;
        int          pre;
        logic [4:0]  g_rd;
        logic [31:0] g_d;
        logic [4:0]  srcs [3];
        logic [7:0]  hz_pat;

        tbl[0]  = mk(1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 2'd0);
        tbl[1]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        2'd0);
        tbl[2]  = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h12345678, 1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        2'd1);
        tbl[3]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b1, 5'd7,  32'h12345678, 2'd0);
        tbl[4]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        2'd0);
        tbl[5]  = mk(1'b1, 5'd0,  32'hAAAA5555, 1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        2'd0);
        tbl[6]  = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h5A5A,     1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        2'd0);
        tbl[7]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        2'd0);
        tbl[8]  = mk(1'b1, 5'd31, 32'h0,        1'b1, 5'd12, 32'hCAFE,     1'b1, 1'b1, 1'b1, 5'd31, 32'h0,        2'd1);
        tbl[9]  = mk(1'b1, 5'd1,  32'h11,       1'b1, 5'd13, 32'hBEEF,     1'b1, 1'b1, 1'b1, 5'd1,  32'h11,       2'd2);
        tbl[10] = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd14, 32'h1414,     1'b1, 1'b0, 1'b1, 5'd12, 32'hCAFE,     2'd1);
        tbl[11] = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd14, 32'h1414,     1'b1, 1'b1, 1'b1, 5'd13, 32'hBEEF,     2'd1);
        tbl[12] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b1, 5'd14, 32'h1414,     2'd0);
        tbl[13] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        2'd0);

        // Reset state
        do_reset();
        chk("rst rf_we",      32'(rf_we),      32'd0);
        chk("rst rf_A3",      32'(rf_A3),      32'd0);
        chk("rst rf_wd",      rf_wd,           32'd0);
        chk("rst fifo_count", 32'(fifo_count), 32'd0);
        chk("rst sec_ready",  32'(sec_ready),  32'd1);
        chk("rst pri_ready",  32'(pri_ready),  32'd1);
        chk("rst hz_stall",   32'(hz_stall),   32'd0);

        // Vector table
        for (int i = 0; i < 14; i++) begin
            idle_in();
            pri_valid = tbl[i].pv; pri_rd = tbl[i].prd; pri_data = tbl[i].pdat;
            sec_valid = tbl[i].sv; sec_rd = tbl[i].srd; sec_data = tbl[i].sdat;
            #1;
            chk($sformatf("tbl%0d pri_ready", i), 32'(pri_ready), 32'(tbl[i].e_pr));
            chk($sformatf("tbl%0d sec_ready", i), 32'(sec_ready), 32'(tbl[i].e_sr));
            tick();
            chk($sformatf("tbl%0d rf_we", i), 32'(rf_we), 32'(tbl[i].e_we));
            if (tbl[i].e_we) begin
                chk($sformatf("tbl%0d rf_A3", i), 32'(rf_A3), 32'(tbl[i].e_a3));
                chk($sformatf("tbl%0d rf_wd", i), rf_wd, tbl[i].e_wd);
            end
            chk($sformatf("tbl%0d fifo_count", i), 32'(fifo_count), 32'(tbl[i].e_cnt));
        end

        // Full FIFO and starvation under a continuous primary stream
        do_reset();
        k = 0;
        for (int c = 0; c < 12; c++) begin
            idle_in();
            pri_valid = 1'b1;
            pri_rd    = 5'(16 + (k % 8));
            pri_data  = 32'hA000 + 32'(k);
            if (c == 0) begin sec_valid = 1'b1; sec_rd = 5'd3; sec_data = 32'h33; end
            if (c == 1) begin sec_valid = 1'b1; sec_rd = 5'd4; sec_data = 32'h44; end
            #1;
            chk($sformatf("starve c%0d pri_ready", c), 32'(pri_ready), (c == 5 || c == 10) ? 32'd0 : 32'd1);
            chk($sformatf("starve c%0d sec_ready", c), 32'(sec_ready), (c >= 2 && c <= 5) ? 32'd0 : 32'd1);
            tick();
            chk($sformatf("starve c%0d rf_we", c), 32'(rf_we), 32'd1);
            if (c == 5 || c == 10) begin
                chk($sformatf("starve c%0d rf_A3", c), 32'(rf_A3), (c == 5) ? 32'd3 : 32'd4);
                chk($sformatf("starve c%0d rf_wd", c), rf_wd, (c == 5) ? 32'h33 : 32'h44);
            end else begin
                chk($sformatf("starve c%0d rf_A3", c), 32'(rf_A3), 32'(16 + (k % 8)));
                chk($sformatf("starve c%0d rf_wd", c), rf_wd, 32'hA000 + 32'(k));
                k++;
            end
        end
        chk("starve primaries accepted", 32'(k), 32'd10);

        // Hazard against a FIFO entry held back by the primary stream
        do_reset();
        hz_pat = 8'b0111_0110;
        for (int c = 0; c < 8; c++) begin
            idle_in();
            pri_valid = (c <= 5);
            pri_rd    = (c <= 5) ? 5'd20 : 5'd0;
            pri_data  = 32'h2000 + 32'(c);
            if (c == 0) begin sec_valid = 1'b1; sec_rd = 5'd9; sec_data = 32'h99; end
            hz_A2 = (c == 1) ? 5'd9 : 5'd0;
            hz_rd = (c == 2) ? 5'd9 : 5'd0;
            hz_A1 = (c >= 4) ? 5'd9 : 5'd0;
            #1;
            chk($sformatf("hz c%0d hz_stall", c), 32'(hz_stall), 32'(hz_pat[c]));
            if (c == 5) chk("hz pop pri_ready", 32'(pri_ready), 32'd0);
            tick();
            if (c == 5) begin
                chk("hz pop rf_we", 32'(rf_we), 32'd1);
                chk("hz pop rf_A3", 32'(rf_A3), 32'd9);
            end
            if (c == 6) chk("hz after rf_we", 32'(rf_we), 32'd0);
        end

        // Reset mid-operation
        do_reset();
        idle_in();
        pri_valid = 1'b1; pri_rd = 5'd21; pri_data = 32'h1;
        sec_valid = 1'b1; sec_rd = 5'd10; sec_data = 32'hA;
        tick();
        pri_rd = 5'd22; pri_data = 32'h2; sec_rd = 5'd11; sec_data = 32'hB;
        tick();
        chk("midrst pre fifo_count", 32'(fifo_count), 32'd2);
        chk("midrst pre rf_we",      32'(rf_we),      32'd1);
        chk("midrst pre rf_A3",      32'(rf_A3),      32'd22);
        idle_in();
        hz_A1 = 5'd10; hz_A2 = 5'd11;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst fifo_count", 32'(fifo_count), 32'd0);
        chk("midrst rf_we",      32'(rf_we),      32'd0);
        chk("midrst rf_A3",      32'(rf_A3),      32'd0);
        chk("midrst sec_ready",  32'(sec_ready),  32'd1);
        chk("midrst pri_ready",  32'(pri_ready),  32'd1);
        chk("midrst hz_stall",   32'(hz_stall),   32'd0);
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("midrst idle%0d rf_we", c), 32'(rf_we), 32'd0);
        end

        // Randomized traffic against a queue-based reference model
        do_reset();
        mq.delete();
        mst = 0; m_we = 1'b0; m_a3 = 5'd0; m_wd = 32'd0;
        for (int n = 0; n < 600; n++) begin
            pri_valid = ($urandom_range(0, 99) < 60);
            pri_rd    = 5'($urandom_range(0, 7));
            pri_data  = $urandom;
            sec_valid = ($urandom_range(0, 99) < 40);
            sec_rd    = 5'($urandom_range(0, 7));
            sec_data  = $urandom;
            hz_A1     = 5'($urandom_range(0, 7));
            hz_A2     = 5'($urandom_range(0, 7));
            hz_rd     = 5'($urandom_range(0, 7));
            rst_now   = ($urandom_range(0, 63) == 0);
            reset     = rst_now;
            #1;
            starved = (mq.size() > 0) && (mst == STARVE);
            srcs[0] = hz_A1; srcs[1] = hz_A2; srcs[2] = hz_rd;
            hz_exp = 1'b0;
            for (int s = 0; s < 3; s++) begin
                if (srcs[s] != 5'd0) begin
                    for (int j = 0; j < mq.size(); j++)
                        if (mq[j].rd == srcs[s]) hz_exp = 1'b1;
                    if (m_we && m_a3 == srcs[s]) hz_exp = 1'b1;
                end
            end
            chk($sformatf("rnd%0d pri_ready", n),  32'(pri_ready),  32'(!starved));
            chk($sformatf("rnd%0d sec_ready", n),  32'(sec_ready),  32'(mq.size() < DEPTH));
            chk($sformatf("rnd%0d hz_stall", n),   32'(hz_stall),   32'(hz_exp));
            chk($sformatf("rnd%0d fifo_count", n), 32'(fifo_count), 32'(mq.size()));
            tick();
            if (rst_now) begin
                mq.delete();
                mst = 0; m_we = 1'b0; m_a3 = 5'd0; m_wd = 32'd0;
            end else begin
                pre = mq.size();
                popped = 1'b0; granted = 1'b0; g_rd = 5'd0; g_d = 32'd0;
                if (starved || (pre > 0 && !pri_valid)) begin
                    g = mq.pop_front();
                    g_rd = g.rd; g_d = g.d; popped = 1'b1; granted = 1'b1;
                end else if (pri_valid) begin
                    g_rd = pri_rd; g_d = pri_data; granted = 1'b1;
                end
                if (popped || pre == 0) mst = 0;
                else if (mst < STARVE) mst++;
                if (sec_valid && pre < DEPTH && sec_rd != 5'd0) begin
                    g.rd = sec_rd; g.d = sec_data;
                    mq.push_back(g);
                end
                m_we = granted && (g_rd != 5'd0);
                if (granted) begin m_a3 = g_rd; m_wd = g_d; end
            end
            reset = 1'b0;
            chk($sformatf("rnd%0d rf_we", n), 32'(rf_we), 32'(m_we));
            if (m_we) begin
                chk($sformatf("rnd%0d rf_A3", n), 32'(rf_A3), 32'(m_a3));
                chk($sformatf("rnd%0d rf_wd", n), rf_wd, m_wd);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
